// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory stage: access-size encodings and the
// load/store unit state type.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align_r0.sv
// Request alignment helper: flags misaligned half/word accesses, clears the
// offending low address bits and replicates store data onto every byte lane.
module lsu_align_r0
    import mips_mem_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BIT_WIDTH-1:0]  wdata,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] addr_aligned,
    output logic [BIT_WIDTH-1:0]  wdata_lanes
);

    // Size decode; both 1x encodings are treated as a word access
    always_comb begin
        misaligned   = 1'b0;
        addr_aligned = addr;
        wdata_lanes  = wdata;
        case (size)
            SIZE_BYTE: begin
                wdata_lanes = {(BIT_WIDTH/8){wdata[7:0]}};
            end
            SIZE_HALF: begin
                misaligned      = addr[0];
                addr_aligned[0] = 1'b0;
                wdata_lanes     = {(BIT_WIDTH/16){wdata[15:0]}};
            end
            default: begin
                misaligned        = (addr[1:0] != 2'b00);
                addr_aligned[1:0] = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit_r0.sv
// Memory-stage load/store initiator driving the dataRAM_r0 port.
// Optional feature: LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit_r0
    import mips_mem_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DELAY      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic                  req_signed,
    input  logic [1:0]            req_size,
    input  logic [31:0]           req_addr,
    input  logic [BIT_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BIT_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_data,
    output logic                  mem_wren,
    output logic                  mem_isSigned,
    output logic [1:0]            mem_dataSize,
    input  logic [BIT_WIDTH-1:0]  mem_q
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (DELAY > 0) ? CNT_W'(DELAY - 1) : {CNT_W{1'b0}};

    lsu_state_e            state_r;
    lsu_state_e            state_nxt_s;
    logic                  wr_r;
    logic                  signed_r;
    logic [1:0]            size_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [BIT_WIDTH-1:0]  wdata_r;
    logic [BIT_WIDTH-1:0]  rdata_r;
    logic                  err_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  rsp_valid_r;
    logic                  busy_r;
    logic                  req_ready_r;
    logic                  accept_s;
    logic                  capture_s;
    logic                  misalign_s;
    logic                  trap_s;
    logic [ADDR_WIDTH-1:0] addr_aligned_s;
    logic [BIT_WIDTH-1:0]  wdata_lanes_s;
    logic                  unused_addr_hi_s;

    lsu_align_r0 #(
        .BIT_WIDTH  (BIT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_align (
        .size         (req_size),
        .addr         (req_addr[ADDR_WIDTH-1:0]),
        .wdata        (req_wdata),
        .misaligned   (misalign_s),
        .addr_aligned (addr_aligned_s),
        .wdata_lanes  (wdata_lanes_s)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s = misalign_s;
`else
    // Misaligned accesses proceed on the masked address, so the flag goes unused
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_s;
    assign trap_s            = 1'b0;
`endif

    assign unused_addr_hi_s = ^req_addr[31:ADDR_WIDTH];
    assign accept_s         = req_valid && (state_r == LSU_IDLE);

    // Next-state decode; capture_s marks the cycle in which mem_q carries the load result
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            LSU_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = trap_s ? LSU_DONE : LSU_REQ;
                end else begin
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (wr_r) begin
                    state_nxt_s = LSU_DONE;
                end else if (DELAY == 0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = LSU_DONE;
                end else begin
                    state_nxt_s = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    capture_s   = 1'b1;
                    state_nxt_s = LSU_DONE;
                end else begin
                    state_nxt_s = LSU_WAIT;
                end
            end
            LSU_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = LSU_IDLE;
                end else begin
                    state_nxt_s = LSU_DONE;
                end
            end
            default: begin
                state_nxt_s = LSU_IDLE;
            end
        endcase
    end

    // State, request capture, latency counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LSU_IDLE;
            wr_r        <= 1'b0;
            signed_r    <= 1'b0;
            size_r      <= 2'b00;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {BIT_WIDTH{1'b0}};
            rdata_r     <= {BIT_WIDTH{1'b0}};
            err_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            rsp_valid_r <= (state_nxt_s == LSU_DONE);
            busy_r      <= (state_nxt_s != LSU_IDLE);
            req_ready_r <= (state_nxt_s == LSU_IDLE);
            if (accept_s) begin
                wr_r     <= req_wr;
                signed_r <= req_signed;
                size_r   <= req_size;
                addr_r   <= addr_aligned_s;
                wdata_r  <= wdata_lanes_s;
                rdata_r  <= {BIT_WIDTH{1'b0}};
                err_r    <= trap_s;
            end else if (capture_s) begin
                rdata_r <= mem_q;
            end
            if (state_r == LSU_REQ) begin
                cnt_r <= CNT_INIT;
            end else if ((state_r == LSU_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // RAM port drive: live only while the request sits at the RAM, zero otherwise
    always_comb begin
        mem_addr     = {ADDR_WIDTH{1'b0}};
        mem_data     = {BIT_WIDTH{1'b0}};
        mem_isSigned = 1'b0;
        mem_dataSize = 2'b00;
        if ((state_r == LSU_REQ) || (state_r == LSU_WAIT)) begin
            mem_addr     = addr_r;
            mem_data     = wdata_r;
            mem_isSigned = signed_r;
            mem_dataSize = size_r;
        end else begin
            mem_addr     = {ADDR_WIDTH{1'b0}};
            mem_data     = {BIT_WIDTH{1'b0}};
            mem_isSigned = 1'b0;
            mem_dataSize = 2'b00;
        end
    end

    // The write strobe is gated by rst directly so an aborted store never reaches the RAM
    assign mem_wren  = (state_r == LSU_REQ) && wr_r && !rst;
    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_load_store_unit_r0.sv
// Bench for load_store_unit_r0: three instances (DELAY 0, 1, 3) share one request
// stream; each has its own RAM model, all are checked against one reference memory.
module tb_load_store_unit_r0;

    localparam int NI = 3;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ram_clr, req_valid, req_wr, req_signed, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready_a    [NI];
    logic        rsp_valid_a    [NI];
    logic [31:0] rsp_rdata_a    [NI];
    logic        rsp_err_a      [NI];
    logic        busy_a         [NI];
    logic [5:0]  mem_addr_a     [NI];
    logic [31:0] mem_data_a     [NI];
    logic        mem_wren_a     [NI];
    logic        mem_isSigned_a [NI];
    logic [1:0]  mem_dataSize_a [NI];
    logic [31:0] mem_q_a        [NI];

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [64];

    function automatic int dl_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_lane
        localparam int D = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [7:0]  ram  [64];
        logic [31:0] pipe [4];
        logic [31:0] rd_s;
        logic [5:0]  a_s;
        logic [7:0]  b0, b1, b2, b3;

        load_store_unit_r0 #(.BIT_WIDTH(32), .ADDR_WIDTH(6), .DELAY(D)) dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_ready    (req_ready_a[g]),
            .req_wr       (req_wr),
            .req_signed   (req_signed),
            .req_size     (req_size),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .rsp_valid    (rsp_valid_a[g]),
            .rsp_ready    (rsp_ready),
            .rsp_rdata    (rsp_rdata_a[g]),
            .rsp_err      (rsp_err_a[g]),
            .busy         (busy_a[g]),
            .mem_addr     (mem_addr_a[g]),
            .mem_data     (mem_data_a[g]),
            .mem_wren     (mem_wren_a[g]),
            .mem_isSigned (mem_isSigned_a[g]),
            .mem_dataSize (mem_dataSize_a[g]),
            .mem_q        (mem_q_a[g])
        );

        // RAM read side: little-endian bytes, extended by the RAM itself
        always_comb begin
            rd_s = 32'h0;
            a_s  = mem_addr_a[g];
            b0   = ram[a_s];
            b1   = ram[a_s + 6'd1];
            b2   = ram[a_s + 6'd2];
            b3   = ram[a_s + 6'd3];
            case (mem_dataSize_a[g])
                2'b00:   rd_s = mem_isSigned_a[g] ? {{24{b0[7]}}, b0} : {24'h0, b0};
                2'b01:   rd_s = mem_isSigned_a[g] ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
                default: rd_s = {b3, b2, b1, b0};
            endcase
        end

        // RAM write side picks the byte lanes addressed, so lane replication matters
        always @(posedge clk) begin
            if (ram_clr) begin
                for (int k = 0; k < 64; k++) ram[k] <= 8'h00;
            end else if (mem_wren_a[g]) begin
                case (mem_dataSize_a[g])
                    2'b00: ram[mem_addr_a[g]] <= mem_data_a[g][8*mem_addr_a[g][1:0] +: 8];
                    2'b01: begin
                        ram[mem_addr_a[g]]         <= mem_data_a[g][16*mem_addr_a[g][1] +: 8];
                        ram[mem_addr_a[g] + 6'd1]  <= mem_data_a[g][16*mem_addr_a[g][1] + 8 +: 8];
                    end
                    default: begin
                        ram[mem_addr_a[g]]        <= mem_data_a[g][7:0];
                        ram[mem_addr_a[g] + 6'd1] <= mem_data_a[g][15:8];
                        ram[mem_addr_a[g] + 6'd2] <= mem_data_a[g][23:16];
                        ram[mem_addr_a[g] + 6'd3] <= mem_data_a[g][31:24];
                    end
                endcase
            end
            pipe[0] <= rd_s;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end

        if (D == 0) begin : g_comb
            assign mem_q_a[g] = rd_s;
        end else begin : g_lat
            assign mem_q_a[g] = pipe[D-1];
        end
    end

    // ---------------- reference model ----------------
    function automatic int nb(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] addr);
        return (int'(addr % 32'd64) % nb(sz)) != 0;
    endfunction

    function automatic logic [5:0] eff_addr(input logic [1:0] sz, input logic [31:0] addr);
        int a;
        a = int'(addr % 32'd64);
        return 6'(a - (a % nb(sz)));
    endfunction

    function automatic logic [31:0] ref_load(input logic sgn, input logic [1:0] sz, input logic [31:0] addr);
        longint v;
        int n, ea;
        v  = 0;
        n  = nb(sz);
        ea = int'(eff_addr(sz, addr));
        for (int k = 0; k < n; k++) v += longint'(ref_mem[ea + k]) << (8 * k);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] w);
        longint unit_v, r;
        int n;
        n      = nb(sz);
        unit_v = longint'(w) & ((longint'(1) << (8 * n)) - 1);
        r      = 0;
        for (int j = 0; j < 4 / n; j++) r |= unit_v << (8 * n * j);
        return r[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] w);
        int ea;
        ea = int'(eff_addr(sz, addr));
        for (int k = 0; k < nb(sz); k++) ref_mem[ea + k] = 8'(w >> (8 * k));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction, checked every cycle on every instance
    task automatic do_txn(input string nm, input logic wr, input logic sgn, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int         first [NI];
        int         exp_first [NI];
        int         act_last [NI];
        int         maxf;
        bit         done, act, err_c;
        logic [5:0] ea;
        logic [31:0] rep;
        string      tag;
        err_c = TRAP && is_mis(sz, addr);
        ea    = eff_addr(sz, addr);
        rep   = lanes(sz, wdata);
        maxf  = 0;
        for (int i = 0; i < NI; i++) begin
            first[i]     = -1;
            exp_first[i] = err_c ? 1 : (wr ? 2 : 2 + dl_of(i));
            act_last[i]  = err_c ? 0 : (wr ? 1 : 1 + dl_of(i));
            if (exp_first[i] > maxf) maxf = exp_first[i];
        end
        @(negedge clk);
        req_wr = wr; req_signed = sgn; req_size = sz; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < NI; i++) chk($sformatf("%s/d%0d/req_ready", nm, dl_of(i)), 32'(req_ready_a[i]), 32'd1);
        @(posedge clk);
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            for (int i = 0; i < NI; i++) begin
                tag = $sformatf("%s/d%0d/c%0d", nm, dl_of(i), k);
                act = (k <= act_last[i]);
                chk({tag, "/mem_addr"}, 32'(mem_addr_a[i]), act ? 32'(ea) : 32'd0);
                chk({tag, "/mem_size"}, 32'(mem_dataSize_a[i]), act ? 32'(sz) : 32'd0);
                chk({tag, "/mem_signed"}, 32'(mem_isSigned_a[i]), act ? 32'(sgn) : 32'd0);
                chk({tag, "/mem_wren"}, 32'(mem_wren_a[i]), (act && wr && k == 1) ? 32'd1 : 32'd0);
                if (!act || wr) chk({tag, "/mem_data"}, mem_data_a[i], act ? rep : 32'd0);
                if (rsp_valid_a[i] && first[i] < 0) begin
                    first[i] = k;
                    chk({tag, "/rsp_latency"}, 32'(k), 32'(exp_first[i]));
                end
                if (first[i] >= 0) begin
                    chk({tag, "/rsp_valid"}, 32'(rsp_valid_a[i]), 32'd1);
                    chk({tag, "/rsp_rdata"}, rsp_rdata_a[i], exp_rdata);
                    chk({tag, "/rsp_err"}, 32'(rsp_err_a[i]), 32'(exp_err));
                end
                chk({tag, "/busy"}, 32'(busy_a[i]), 32'd1);
                chk({tag, "/req_ready"}, 32'(req_ready_a[i]), 32'd0);
            end
            done = (k >= maxf + hold);
            for (int i = 0; i < NI; i++) if (first[i] < 0) done = 1'b0;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s/timeout: response missing after 40 cycles, required within %0d", nm, maxf);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tag = $sformatf("%s/d%0d/after", nm, dl_of(i));
            chk({tag, "/busy"}, 32'(busy_a[i]), 32'd0);
            chk({tag, "/req_ready"}, 32'(req_ready_a[i]), 32'd1);
            chk({tag, "/rsp_valid"}, 32'(rsp_valid_a[i]), 32'd0);
        end
        if (wr && !err_c) ref_store(sz, addr, wdata);
    endtask

    typedef struct {
        logic        wr;
        logic        sgn;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic        r_wr, r_sgn, r_err;
        logic [1:0]  r_sz;
        logic [31:0] r_addr, r_wdata, r_exp;

        vt[0]  = '{1'b1, 1'b0, 2'b10, 32'h00, 32'h80010000, 0, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 2'b01, 32'h02, 32'h0,        0, 32'hFFFF8001, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 2'b01, 32'h02, 32'h0,        5, 32'h00008001, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 2'b00, 32'h03, 32'h000000AB, 0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 2'b10, 32'h00, 32'h0,        1, 32'hAB010000, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 2'b00, 32'h03, 32'h0,        0, 32'hFFFFFFAB, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 2'b10, 32'h04, 32'h12345678, 0, 32'h0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFC3, 32'h0, 0, 32'h000000AB, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vt[7]  = '{1'b0, 1'b0, 2'b10, 32'h05, 32'h0,        0, 32'h0, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 2'b01, 32'h07, 32'h0000BEEF, 0, 32'h0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 2'b10, 32'h04, 32'h0,        0, 32'h12345678, 1'b0};
        vt[11] = '{1'b0, 1'b1, 2'b01, 32'h01, 32'h0,        2, 32'h0, 1'b1};
`else
        vt[7]  = '{1'b0, 1'b0, 2'b10, 32'h05, 32'h0,        0, 32'h12345678, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 2'b01, 32'h07, 32'h0000BEEF, 0, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 2'b10, 32'h04, 32'h0,        0, 32'hBEEF5678, 1'b0};
        vt[11] = '{1'b0, 1'b1, 2'b01, 32'h01, 32'h0,        2, 32'h0, 1'b0};
`endif

        rst = 1'b1; ram_clr = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_signed = 1'b0;
        rsp_ready = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        for (int a = 0; a < 64; a++) ref_mem[a] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset/d%0d/req_ready", dl_of(i)), 32'(req_ready_a[i]), 32'd1);
            chk($sformatf("reset/d%0d/busy", dl_of(i)), 32'(busy_a[i]), 32'd0);
            chk($sformatf("reset/d%0d/rsp_valid", dl_of(i)), 32'(rsp_valid_a[i]), 32'd0);
            chk($sformatf("reset/d%0d/rsp_rdata", dl_of(i)), rsp_rdata_a[i], 32'd0);
            chk($sformatf("reset/d%0d/rsp_err", dl_of(i)), 32'(rsp_err_a[i]), 32'd0);
            chk($sformatf("reset/d%0d/mem_wren", dl_of(i)), 32'(mem_wren_a[i]), 32'd0);
            chk($sformatf("reset/d%0d/mem_addr", dl_of(i)), 32'(mem_addr_a[i]), 32'd0);
        end
        rst = 1'b0; ram_clr = 1'b0;

        for (int v = 0; v < 12; v++) begin
            do_txn($sformatf("vec%0d", v), vt[v].wr, vt[v].sgn, vt[v].sz, vt[v].addr,
                   vt[v].wdata, vt[v].hold, vt[v].exp_rdata, vt[v].exp_err);
        end

        // Reset in the REQ cycle of a store: the write must never happen
        do_txn("pre_sw8", 1'b1, 1'b0, 2'b10, 32'h08, 32'h11223344, 0, 32'h0, 1'b0);
        @(negedge clk);
        req_wr = 1'b1; req_signed = 1'b0; req_size = 2'b10; req_addr = 32'h08; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("rst_req/d%0d/mem_wren", dl_of(i)), 32'(mem_wren_a[i]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_req/d%0d/busy", dl_of(i)), 32'(busy_a[i]), 32'd0);
            chk($sformatf("rst_req/d%0d/req_ready", dl_of(i)), 32'(req_ready_a[i]), 32'd1);
            chk($sformatf("rst_req/d%0d/rsp_valid", dl_of(i)), 32'(rsp_valid_a[i]), 32'd0);
        end
        do_txn("post_rst_lw8", 1'b0, 1'b0, 2'b10, 32'h08, 32'h0, 0, 32'h11223344, 1'b0);

        // Random traffic against the reference memory
        for (int n = 0; n < 60; n++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_sgn   = 1'($urandom_range(0, 1));
            r_sz    = 2'($urandom_range(0, 3));
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_err   = TRAP && is_mis(r_sz, r_addr);
            r_exp   = (r_wr || r_err) ? 32'h0 : ref_load(r_sgn, r_sz, r_addr);
            do_txn($sformatf("rnd%0d", n), r_wr, r_sgn, r_sz, r_addr, r_wdata,
                   int'($urandom_range(0, 3)), r_exp, r_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
